// File: rtl/sp_mem_bist_if.sv
// sp_mem_bist_if
// Request/response bus between the BIST engine and the single-port memory.
//   master (BIST side):  drives wr_rd, valid, wdata, addr; samples rdata, ready
//   slave  (memory side): samples wr_rd, valid, wdata, addr; drives rdata, ready
// A transfer completes in any cycle with valid && ready.
interface sp_mem_bist_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
);
  logic                  wr_rd;
  logic                  valid;
  logic [DATA_WIDTH-1:0] wdata;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  ready;

  modport master (output wr_rd, valid, wdata, addr, input rdata, ready);
  modport slave  (input wr_rd, valid, wdata, addr, output rdata, ready);
endinterface

// File: rtl/sp_mem_bist.sv
// sp_mem_bist
// March-style built-in self-test for a single-port memory. Runs four phases
// over addresses 0..DEPTH-1: write pattern A, read-compare A, write pattern B,
// read-compare B. Pattern A(addr) = SEED ^ addr, pattern B = ~A(addr).
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   start      one-cycle request to begin a test (accepted in IDLE or DONE)
//   mem        memory request bus (master modport of sp_mem_bist_if)
//   busy       test in progress
//   done       test finished, held until next accepted start or rst
//   pass       1 = no mismatches (valid while done)
//   err_cnt    saturating mismatch count (only with SP_MEM_BIST_ERR_CNT_EN)
//   fail_addr  address of the first mismatch, 0 if none
// Optional feature macro: SP_MEM_BIST_ERR_CNT_EN
module sp_mem_bist #(
  parameter int         ADDR_WIDTH = 4,
  parameter int         DATA_WIDTH = 8,
  parameter int         DEPTH      = 16,
  parameter logic [7:0] SEED       = 8'hA5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  sp_mem_bist_if.master         mem,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
`ifdef SP_MEM_BIST_ERR_CNT_EN
  output logic [ADDR_WIDTH+1:0] err_cnt,
`endif
  output logic [ADDR_WIDTH-1:0] fail_addr
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_WR_A = 3'd1;
  localparam logic [2:0] ST_RD_A = 3'd2;
  localparam logic [2:0] ST_WR_B = 3'd3;
  localparam logic [2:0] ST_RD_B = 3'd4;
  localparam logic [2:0] ST_DONE = 3'd5;

  localparam logic [DATA_WIDTH-1:0] SEED_W    = DATA_WIDTH'(SEED);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  // Test pattern for an address; inv selects pattern B.
  function automatic logic [DATA_WIDTH-1:0] pattern_f(input logic [ADDR_WIDTH-1:0] a,
                                                      input logic inv);
    logic [DATA_WIDTH-1:0] p;
    p = SEED_W ^ DATA_WIDTH'(a);
    return inv ? ~p : p;
  endfunction

  // Write data presented for a given phase/address; reads drive zero.
  function automatic logic [DATA_WIDTH-1:0] wdata_f(input logic [2:0] st,
                                                    input logic [ADDR_WIDTH-1:0] a);
    logic [DATA_WIDTH-1:0] d;
    case (st)
      ST_WR_A: d = pattern_f(a, 1'b0);
      ST_WR_B: d = pattern_f(a, 1'b1);
      default: d = {DATA_WIDTH{1'b0}};
    endcase
    return d;
  endfunction

  logic [2:0]            state_r;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic                  valid_r;
  logic                  wr_rd_r;
  logic [DATA_WIDTH-1:0] wdata_r;
  logic                  busy_r;
  logic                  done_r;
  logic                  pass_r;
  logic                  fail_r;
  logic [ADDR_WIDTH-1:0] fail_addr_r;
  // Registered compare result: the final read is resolved one cycle after its
  // handshake, which is why done rises one cycle after the last transfer.
  logic                  cmp_err_r;
  logic [ADDR_WIDTH-1:0] cmp_addr_r;

  logic                  hs_s;
  logic                  last_s;
  logic                  is_rd_s;
  logic                  launch_s;
  logic [2:0]            nxt_phase_s;
  logic [2:0]            nxt_state_s;
  logic [ADDR_WIDTH-1:0] nxt_addr_s;
  logic [DATA_WIDTH-1:0] exp_s;

  // Next-request sequencing and start acceptance.
  always_comb begin
    hs_s     = valid_r & mem.ready;
    last_s   = (addr_r == LAST_ADDR);
    is_rd_s  = (state_r == ST_RD_A) || (state_r == ST_RD_B);
    exp_s    = pattern_f(addr_r, state_r == ST_RD_B);
    launch_s = start && ((state_r == ST_IDLE) || ((state_r == ST_DONE) && done_r));
    case (state_r)
      ST_WR_A: nxt_phase_s = ST_RD_A;
      ST_RD_A: nxt_phase_s = ST_WR_B;
      ST_WR_B: nxt_phase_s = ST_RD_B;
      ST_RD_B: nxt_phase_s = ST_DONE;
      default: nxt_phase_s = ST_IDLE;
    endcase
    if (last_s) begin
      nxt_state_s = nxt_phase_s;
      nxt_addr_s  = {ADDR_WIDTH{1'b0}};
    end else begin
      nxt_state_s = state_r;
      nxt_addr_s  = addr_r + ADDR_WIDTH'(1'b1);
    end
  end

  // Main FSM, request registers and result capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      addr_r      <= {ADDR_WIDTH{1'b0}};
      valid_r     <= 1'b0;
      wr_rd_r     <= 1'b0;
      wdata_r     <= {DATA_WIDTH{1'b0}};
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      pass_r      <= 1'b0;
      fail_r      <= 1'b0;
      fail_addr_r <= {ADDR_WIDTH{1'b0}};
      cmp_err_r   <= 1'b0;
      cmp_addr_r  <= {ADDR_WIDTH{1'b0}};
    end else begin
      cmp_err_r <= 1'b0;
      // First mismatch wins; later ones leave fail_addr alone.
      if (cmp_err_r && !fail_r) begin
        fail_r      <= 1'b1;
        fail_addr_r <= cmp_addr_r;
      end
      if (launch_s) begin
        state_r     <= ST_WR_A;
        addr_r      <= {ADDR_WIDTH{1'b0}};
        valid_r     <= 1'b1;
        wr_rd_r     <= 1'b1;
        wdata_r     <= pattern_f({ADDR_WIDTH{1'b0}}, 1'b0);
        busy_r      <= 1'b1;
        done_r      <= 1'b0;
        pass_r      <= 1'b0;
        fail_r      <= 1'b0;
        fail_addr_r <= {ADDR_WIDTH{1'b0}};
      end else begin
        case (state_r)
          ST_WR_A, ST_RD_A, ST_WR_B, ST_RD_B: begin
            if (hs_s) begin
              cmp_err_r  <= is_rd_s && (mem.rdata != exp_s);
              cmp_addr_r <= addr_r;
              state_r    <= nxt_state_s;
              addr_r     <= nxt_addr_s;
              valid_r    <= (nxt_state_s != ST_DONE);
              wr_rd_r    <= (nxt_state_s == ST_WR_A) || (nxt_state_s == ST_WR_B);
              wdata_r    <= wdata_f(nxt_state_s, nxt_addr_s);
            end
          end
          ST_DONE: begin
            // Fold in the compare of the last read before reporting.
            if (!done_r) begin
              done_r <= 1'b1;
              busy_r <= 1'b0;
              pass_r <= !(fail_r || cmp_err_r);
            end
          end
          ST_IDLE: ;
          default: state_r <= ST_IDLE;
        endcase
      end
    end
  end

`ifdef SP_MEM_BIST_ERR_CNT_EN
  logic [ADDR_WIDTH+1:0] err_cnt_r;

  // Saturating mismatch counter, cleared on each accepted start.
  always_ff @(posedge clk) begin
    if (rst || launch_s) begin
      err_cnt_r <= {(ADDR_WIDTH+2){1'b0}};
    end else if (cmp_err_r && (err_cnt_r != {(ADDR_WIDTH+2){1'b1}})) begin
      err_cnt_r <= err_cnt_r + (ADDR_WIDTH+2)'(1'b1);
    end
  end

  assign err_cnt = err_cnt_r;
`endif

  assign mem.valid = valid_r;
  assign mem.wr_rd = wr_rd_r;
  assign mem.wdata = wdata_r;
  assign mem.addr  = addr_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign pass      = pass_r;
  assign fail_addr = fail_addr_r;

endmodule

// File: tb/tb_sp_mem_bist.sv
// tb_sp_mem_bist
// Self-checking bench for sp_mem_bist: memory model with per-phase read
// fault masks, ready stall injection, and a request/result reference model.
module tb_sp_mem_bist;
  localparam int         DEPTH = 16;
  localparam logic [7:0] SEED  = 8'hA5;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic busy, done, pass;
  logic [3:0] fail_addr;
`ifdef SP_MEM_BIST_ERR_CNT_EN
  logic [5:0] err_cnt;
`endif

  sp_mem_bist_if #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) mif ();

  sp_mem_bist #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .DEPTH(DEPTH), .SEED(SEED)) dut (
    .clk(clk), .rst(rst), .start(start), .mem(mif),
    .busy(busy), .done(done), .pass(pass),
`ifdef SP_MEM_BIST_ERR_CNT_EN
    .err_cnt(err_cnt),
`endif
    .fail_addr(fail_addr)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  logic [7:0] mem [DEPTH];
  logic [7:0] flt_a [DEPTH];
  logic [7:0] flt_b [DEPTH];
  int   hs_cnt = 0;
  int   run_no = 0;
  logic clr_hs = 1'b0;
  logic ready_r = 1'b1;
  logic [7:0] rdata_s;
  int   stall_at = -1;
  int   stall_len = 0;
  int   stall_cnt = 0;
  int   stall_tot = 0;
  int   last_run = 0;
  logic rand_rdy = 1'b0;

  assign mif.ready = ready_r;
  assign mif.rdata = rdata_s;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference request for the n-th transfer of a test.
  function automatic void exp_req(input int n, output logic wr, output logic [3:0] a,
                                  output logic [7:0] d);
    int ph;
    ph = n / DEPTH;
    a  = 4'(n % DEPTH);
    wr = (ph % 2 == 0);
    if (ph == 0)      d = SEED ^ {4'h0, a};
    else if (ph == 2) d = ~(SEED ^ {4'h0, a});
    else              d = 8'h00;
  endfunction

  // Reference results from the injected fault masks.
  function automatic void exp_res(output logic p, output logic [3:0] fa, output int cnt);
    logic [7:0] m;
    p = 1'b1; fa = 4'h0; cnt = 0;
    for (int n = 0; n < 2 * DEPTH; n++) begin
      m = (n < DEPTH) ? flt_a[n] : flt_b[n - DEPTH];
      if (m != 8'h00) begin
        if (p) fa = 4'(n % DEPTH);
        p = 1'b0;
        cnt++;
      end
    end
  endfunction

  // Memory model: rdata is stored data with the phase's fault mask applied.
  always_comb begin
    logic [7:0] msk;
    msk = 8'h00;
    if (hs_cnt / DEPTH == 1)      msk = flt_a[mif.addr];
    else if (hs_cnt / DEPTH == 3) msk = flt_b[mif.addr];
    rdata_s = mem[mif.addr] ^ msk;
  end

  // Memory writes and transfer counting.
  always @(posedge clk) begin
    if (clr_hs) begin
      hs_cnt <= 0;
      run_no <= run_no + 1;
    end else if (mif.valid && mif.ready) begin
      hs_cnt <= hs_cnt + 1;
    end
    if (mif.valid && mif.ready && mif.wr_rd) mem[mif.addr] <= mif.wdata;
  end

  // Ready driver and request monitor.
  always @(negedge clk) begin
    logic       ewr;
    logic [3:0] ea;
    logic [7:0] ed;
    if (run_no != last_run) begin
      stall_cnt = 0;
      stall_tot = 0;
      last_run  = run_no;
    end
    if (stall_at >= 0 && hs_cnt == stall_at && stall_cnt < stall_len) begin
      ready_r = 1'b0;
      stall_cnt++;
    end else if (rand_rdy) begin
      ready_r = ($urandom_range(0, 3) != 0);
    end else begin
      ready_r = 1'b1;
    end
    if (mif.valid === 1'b1) begin
      if (!ready_r) stall_tot++;
      chk("req_in_range", 32'(hs_cnt < 4 * DEPTH), 32'd1);
      exp_req(hs_cnt, ewr, ea, ed);
      chk("req_wr_rd", 32'(mif.wr_rd), 32'(ewr));
      chk("req_addr", 32'(mif.addr), 32'(ea));
      chk("req_wdata", 32'(mif.wdata), 32'(ed));
      chk("req_busy", 32'(busy), 32'd1);
    end
  end

  // Start a test and wait (bounded) for done; optional start pulse while busy.
  task automatic run(input int pulse_idx, output int cyc);
    bit pulsed;
    pulsed = 1'b0;
    @(negedge clk);
    start = 1'b1; clr_hs = 1'b1;
    @(posedge clk);
    cyc = 1;
    @(negedge clk);
    start = 1'b0; clr_hs = 1'b0;
    while (!done && cyc < 400) begin
      if (pulse_idx >= 0 && hs_cnt == pulse_idx && !pulsed) begin
        start = 1'b1; pulsed = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic check_run(input int cyc, input int exp_lat);
    logic       ep;
    logic [3:0] efa;
    int         ecnt;
    exp_res(ep, efa, ecnt);
    chk("latency", 32'(cyc), 32'(exp_lat));
    chk("done", 32'(done), 32'd1);
    chk("busy_end", 32'(busy), 32'd0);
    chk("valid_end", 32'(mif.valid), 32'd0);
    chk("transfers", 32'(hs_cnt), 32'(4 * DEPTH));
    chk("pass", 32'(pass), 32'(ep));
    chk("fail_addr", 32'(fail_addr), 32'(efa));
`ifdef SP_MEM_BIST_ERR_CNT_EN
    chk("err_cnt", 32'(err_cnt), 32'(ecnt));
`endif
  endtask

  task automatic clear_faults();
    for (int i = 0; i < DEPTH; i++) begin
      flt_a[i] = 8'h00;
      flt_b[i] = 8'h00;
    end
  endtask

  initial begin
    int cyc;
    int guard;
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'h00;
    clear_faults();
    rst = 1'b1; start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_pass", 32'(pass), 32'd0);
    chk("rst_fail_addr", 32'(fail_addr), 32'd0);
    chk("rst_valid", 32'(mif.valid), 32'd0);
    chk("rst_wr_rd", 32'(mif.wr_rd), 32'd0);
    chk("rst_addr", 32'(mif.addr), 32'd0);
    chk("rst_wdata", 32'(mif.wdata), 32'd0);
`ifdef SP_MEM_BIST_ERR_CNT_EN
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
`endif
    rst = 1'b0;

    // Clean memory, ready always high.
    run(-1, cyc);
    check_run(cyc, 4 * DEPTH + 2);
    chk("clean_latency66", 32'(cyc), 32'd66);

    // Single fault in RD_B at address 5.
    flt_b[5] = 8'h01;
    run(-1, cyc);
    check_run(cyc, 66);
    chk("fault5_fail_addr", 32'(fail_addr), 32'd5);

    // Faults at 3 (RD_A) and 9 (RD_A and RD_B).
    clear_faults();
    flt_a[3] = 8'h01; flt_a[9] = 8'h10; flt_b[9] = 8'h80;
    run(-1, cyc);
    check_run(cyc, 66);
    chk("multi_fail_addr", 32'(fail_addr), 32'd3);

    // Three-cycle stall at WR_A address 7.
    clear_faults();
    stall_at = 7; stall_len = 3;
    run(-1, cyc);
    check_run(cyc, 66 + stall_tot);
    chk("stall_latency69", 32'(cyc), 32'd69);
    stall_at = -1;

    // Start pulse while busy (RD_A address 4) must be ignored.
    run(DEPTH + 4, cyc);
    check_run(cyc, 66);

    // Reset in the middle of RD_A, then a clean restart.
    @(negedge clk);
    start = 1'b1; clr_hs = 1'b1;
    @(negedge clk);
    start = 1'b0; clr_hs = 1'b0;
    guard = 0;
    while (hs_cnt != DEPTH + 7 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    chk("reach_rd_a7", 32'(hs_cnt), 32'(DEPTH + 7));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_valid", 32'(mif.valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    run(-1, cyc);
    check_run(cyc, 66);

    // Randomized fault masks and random ready back-pressure.
    rand_rdy = 1'b1;
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < DEPTH; i++) begin
        flt_a[i] = ($urandom_range(0, 5) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
        flt_b[i] = ($urandom_range(0, 5) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      end
      run(-1, cyc);
      check_run(cyc, 66 + stall_tot);
    end
    rand_rdy = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
